regfile_writeback_queue: RTL and testbench

//  Writer-side front end for the 32x64 register file. Buffers completed results (rd, data)

---
 rtl/regfile_pkg.sv | 17 +
 rtl/wbq_bypass_match.sv | 40 ++++
 rtl/regfile_writeback_queue.sv | 123 ++++++++++++
 tb/tb_regfile_writeback_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file writeback path.
//   NUM_REGS    : architectural register count
//   XLEN        : register data width
//   REG_AW      : register-number width
//   wbq_entry_t : one pending write (destination register + value)
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int XLEN     = 64;
    localparam int REG_AW   = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_bypass_match.sv
// Bypass lookup over the writeback queue: finds the youngest valid entry whose
// rd matches i_reg. Register 0 never matches.
//   i_entries : queue storage, indexed by physical slot
//   i_valid   : per-slot occupancy mask
//   i_head    : slot of the oldest entry
//   i_reg     : register number being read by decode
//   o_hit     : a pending value exists for i_reg
//   o_data    : youngest pending value, 0 when no hit
module wbq_bypass_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wbq_entry_t [DEPTH-1:0] i_entries,
    input  logic [DEPTH-1:0]       i_valid,
    input  logic [PTR_W-1:0]       i_head,
    input  logic [REG_AW-1:0]      i_reg,
    output logic                   o_hit,
    output logic [XLEN-1:0]        o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest; a later match overrides an earlier one, so the
    // youngest pending value is what decode sees.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_valid[w_idx] && (i_reg != '0) && (i_entries[w_idx].rd == i_reg)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writer-side front end of the 32x64 register file. Completed results are
// queued in a small FIFO and drained one per cycle onto the file's write port;
// two bypass ports let decode see values still waiting in the queue.
// Writes to x0 are accepted and dropped.
// Optional feature: define WBQ_COALESCE_EN to merge a result into the youngest
// queued entry when both target the same register.
//   clock/reset_n        : clock, async active-low reset
//   in_valid/in_ready    : producer handshake (in_ready = not full)
//   in_rd/in_data        : result destination and value
//   RegWrite/WriteReg/WriteData : register file write port (head entry)
//   look{1,2}_reg/_hit/_data    : decode bypass lookups
// XLEN/REG_AW must match regfile_pkg (the entry struct uses the package widths).
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_data,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteReg,
    output logic [XLEN-1:0]   WriteData,
    input  logic [REG_AW-1:0] look1_reg,
    output logic              look1_hit,
    output logic [XLEN-1:0]   look1_data,
    input  logic [REG_AW-1:0] look2_reg,
    output logic              look2_hit,
    output logic [XLEN-1:0]   look2_data
);
    import regfile_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbq_entry_t [DEPTH-1:0] r_entries;
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_valid;

    assign in_ready   = (r_count != CNT_W'(DEPTH));
    assign w_push_req = in_valid && in_ready && (in_rd != '0);
    // The file always accepts, so any occupied head drains this cycle.
    assign w_pop      = (r_count != '0);

`ifdef WBQ_COALESCE_EN
    logic [PTR_W-1:0] w_tail_m1;
    logic             w_coal;
    assign w_tail_m1 = r_tail - 1'b1;
    // A lone entry that is leaving this cycle cannot absorb the new value.
    assign w_coal = w_push_req && (r_count != '0) && !((r_count == CNT_W'(1)) && w_pop)
                    && (r_entries[w_tail_m1].rd == in_rd);
    assign w_push = w_push_req && !w_coal;
`else
    assign w_push = w_push_req;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_entries <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= '{rd: in_rd, data: in_data};
                r_tail            <= r_tail + 1'b1;
            end
`ifdef WBQ_COALESCE_EN
            if (w_coal) begin
                r_entries[w_tail_m1].data <= in_data;
            end
`endif
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign RegWrite  = w_pop;
    assign WriteReg  = w_pop ? r_entries[r_head].rd   : '0;
    assign WriteData = w_pop ? r_entries[r_head].data : '0;

    // Slot i is occupied when its distance from head is below the count.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = ({1'b0, PTR_W'(i) - r_head} < r_count);
        end
    end

    wbq_bypass_match #(.DEPTH(DEPTH)) u_look1 (
        .i_entries (r_entries),
        .i_valid   (w_valid),
        .i_head    (r_head),
        .i_reg     (look1_reg),
        .o_hit     (look1_hit),
        .o_data    (look1_data)
    );

    wbq_bypass_match #(.DEPTH(DEPTH)) u_look2 (
        .i_entries (r_entries),
        .i_valid   (w_valid),
        .i_head    (r_head),
        .i_reg     (look2_reg),
        .o_hit     (look2_hit),
        .o_data    (look2_data)
    );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: a queue-of-pending-writes model checked
// against the DUT on every falling edge, plus literal expectations for the
// directed scenarios.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [63:0] in_data;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    logic [4:0]  look1_reg, look2_reg;
    logic        look1_hit, look2_hit;
    logic [63:0] look1_data, look2_data;

    int n_chk = 0;
    int n_err = 0;

    regfile_writeback_queue #(.DEPTH(DEPTH), .XLEN(64), .REG_AW(5)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .look1_reg(look1_reg), .look1_hit(look1_hit), .look1_data(look1_data),
        .look2_reg(look2_reg), .look2_hit(look2_hit), .look2_data(look2_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: ordered list of pending writes ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } pend_t;
    pend_t q[$];

    always @(posedge clock or negedge reset_n) begin
        bit    acc;
        int    n0;
        pend_t e;
        if (!reset_n) begin
            q.delete();
        end else begin
            n0  = q.size();
            acc = in_valid && (n0 != DEPTH);
            if (n0 > 0) void'(q.pop_front());
            if (acc && in_rd != 0) begin
                e.rd   = in_rd;
                e.data = in_data;
`ifdef WBQ_COALESCE_EN
                if (n0 >= 2 && q[q.size()-1].rd == in_rd) q[q.size()-1] = e;
                else q.push_back(e);
`else
                q.push_back(e);
`endif
            end
        end
    end

    function automatic void mlook(input logic [4:0] r, output logic hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (r != 0) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].rd == r) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end
            end
        end
    endfunction

    always @(negedge clock) begin
        logic        h;
        logic [63:0] d;
        chk("m_in_ready", in_ready, q.size() != DEPTH);
        chk("m_RegWrite", RegWrite, q.size() != 0);
        chk("m_WriteReg", WriteReg, (q.size() != 0) ? 64'(q[0].rd) : 64'd0);
        chk("m_WriteData", WriteData, (q.size() != 0) ? q[0].data : 64'd0);
        mlook(look1_reg, h, d);
        chk("m_look1_hit", look1_hit, h);
        chk("m_look1_data", look1_data, d);
        mlook(look2_reg, h, d);
        chk("m_look2_hit", look2_hit, h);
        chk("m_look2_data", look2_data, d);
    end

    // ---------------- stimulus ----------------
    task automatic sync();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [63:0] d);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [63:0] d;
    } vec_t;
    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 5'd3,  64'hA1};
        vecs[1]  = '{1'b1, 5'd3,  64'hA2};
        vecs[2]  = '{1'b0, 5'd3,  64'hA3};
        vecs[3]  = '{1'b1, 5'd0,  64'hA4};
        vecs[4]  = '{1'b1, 5'd31, 64'hFFFF_0000_1234_5678};
        vecs[5]  = '{1'b1, 5'd31, 64'h1};
        vecs[6]  = '{1'b1, 5'd8,  64'hCAFE};
        vecs[7]  = '{1'b0, 5'd8,  64'h0};
        vecs[8]  = '{1'b1, 5'd8,  64'hBEEF};
        vecs[9]  = '{1'b1, 5'd1,  64'h5555_AAAA_5555_AAAA};
        vecs[10] = '{1'b1, 5'd3,  64'h77};
        vecs[11] = '{1'b0, 5'd0,  64'h0};

        reset_n   = 1'b0;
        look1_reg = 5'd3;
        look2_reg = 5'd0;
        drive(1'b1, 5'd3, 64'h99);          // push while held in reset
        repeat (3) sync();
        chk("rst_RegWrite", RegWrite, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_look1_hit", look1_hit, 1'b0);
        chk("rst_WriteReg", WriteReg, 5'd0);
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 64'h0);
        sync();
        chk("rst_push_ignored", RegWrite, 1'b0);

        // single push: write visible the cycle after acceptance, gone after
        drive(1'b1, 5'd5, 64'hDEAD);
        sync();
        drive(1'b0, 5'd0, 64'h0);
        chk("single_RegWrite", RegWrite, 1'b1);
        chk("single_WriteReg", WriteReg, 5'd5);
        chk("single_WriteData", WriteData, 64'hDEAD);
        sync();
        chk("single_drained", RegWrite, 1'b0);

        // back-to-back pushes: drain keeps pace, in_ready never drops
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 64'(i * 16));
            chk("burst_in_ready", in_ready, 1'b1);
            if (i > 1) chk("burst_WriteReg", WriteReg, 64'(i - 1));
            sync();
        end
        drive(1'b0, 5'd0, 64'h0);
        chk("burst_last_WriteReg", WriteReg, 5'd4);
        chk("burst_last_WriteData", WriteData, 64'h40);
        sync();

        // bypass: youngest value for rd 7, x0 lookup never hits
        look1_reg = 5'd7;
        look2_reg = 5'd0;
        drive(1'b1, 5'd7, 64'h11);
        sync();
        chk("byp_first_hit", look1_hit, 1'b1);
        chk("byp_first_data", look1_data, 64'h11);
        drive(1'b1, 5'd7, 64'h22);
        sync();
        drive(1'b0, 5'd0, 64'h0);
        chk("byp_hit", look1_hit, 1'b1);
        chk("byp_data", look1_data, 64'h22);
        chk("byp_x0_hit", look2_hit, 1'b0);
        chk("byp_x0_data", look2_data, 64'h0);
        sync();
        chk("byp_empty_hit", look1_hit, 1'b0);
        chk("byp_empty_data", look1_data, 64'h0);

        // x0 writes are accepted and dropped
        drive(1'b1, 5'd0, 64'hFF);
        chk("x0_in_ready", in_ready, 1'b1);
        sync();
        drive(1'b0, 5'd0, 64'h0);
        chk("x0_RegWrite", RegWrite, 1'b0);
        chk("x0_in_ready_after", in_ready, 1'b1);

        // mixed vector table, checked by the model each cycle
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                look1_reg = 5'd8;
                look2_reg = 5'd31;
            end else if (i == 0) begin
                look1_reg = 5'd3;
                look2_reg = 5'd31;
            end
            drive(vecs[i].v, vecs[i].rd, vecs[i].d);
            sync();
        end
        drive(1'b0, 5'd0, 64'h0);
        sync();

        // async reset while writes are pending
        look1_reg = 5'd12;
        drive(1'b1, 5'd10, 64'hA);
        sync();
        drive(1'b1, 5'd11, 64'hB);
        sync();
        drive(1'b1, 5'd12, 64'hC);
        sync();
        drive(1'b0, 5'd0, 64'h0);
        chk("mid_RegWrite", RegWrite, 1'b1);
        chk("mid_WriteReg", WriteReg, 5'd12);
        chk("mid_look1_hit", look1_hit, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_RegWrite", RegWrite, 1'b0);
        chk("async_WriteReg", WriteReg, 5'd0);
        chk("async_look1_hit", look1_hit, 1'b0);
        chk("async_in_ready", in_ready, 1'b1);
        sync();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sync();
            chk("post_rst_quiet", RegWrite, 1'b0);
        end

`ifdef WBQ_COALESCE_EN
        look1_reg = 5'd9;
        drive(1'b1, 5'd9, 64'h1);
        sync();
        drive(1'b1, 5'd9, 64'h2);
        sync();
        drive(1'b0, 5'd0, 64'h0);
        repeat (3) sync();
`endif

        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
